// File: rtl/mod_addsub_pipe_if.sv
// mod_addsub_pipe_if
//   Operand/result bundle for mod_addsub_pipe.
//   master : the operand producer (drives operands, mode, intt, hold; reads results)
//   slave  : the arithmetic block
//   Signals:
//     in_valid  operand qualifier
//     in_a      operand A, AH=[23:12], AL=[11:0]
//     in_b      operand B, BH=[23:12], BL=[11:0]
//     mode      0=K2, 1=K4, 2=D_ADD, 3=D_SUB
//     intt      0=NTT (BH delayed in K4), 1=INTT (BH undelayed)
//     hold      global pipeline freeze
//     out_valid result qualifier
//     out_sum   result word
interface mod_addsub_pipe_if;
  logic        in_valid;
  logic [23:0] in_a;
  logic [23:0] in_b;
  logic [1:0]  mode;
  logic        intt;
  logic        hold;
  logic        out_valid;
  logic [23:0] out_sum;

  modport master (
    output in_valid, in_a, in_b, mode, intt, hold,
    input  out_valid, out_sum
  );

  modport slave (
    input  in_valid, in_a, in_b, mode, intt, hold,
    output out_valid, out_sum
  );
endinterface

// File: rtl/mod_addsub_pipe.sv
// mod_addsub_pipe
//   Pipelined modular add/subtract unit for lattice crypto butterflies.
//   Works either on two 12-bit Kyber lanes (modulus KQ) or on one 24-bit
//   Dilithium word (modulus DQ). Each result uses a single conditional
//   correction. In K4/NTT operation the high half of B is taken from a
//   BH_DLY-deep delay line.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset (wins over hold)
//     bus  mod_addsub_pipe_if.slave (operands, mode, intt, hold, results)
//   Parameters:
//     KQ      lane modulus
//     DQ      word modulus
//     PIPE    register stages input->output (1 or 2)
//     BH_DLY  delay of BH in K4 NTT mode (0..15)
module mod_addsub_pipe #(
  parameter int KQ     = 3329,
  parameter int DQ     = 8380417,
  parameter int PIPE   = 2,
  parameter int BH_DLY = 6
) (
  input logic              clk,
  input logic              rst,
  mod_addsub_pipe_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_K2   = 2'd0,
    MODE_K4   = 2'd1,
    MODE_DADD = 2'd2,
    MODE_DSUB = 2'd3
  } mode_t;

  localparam logic [12:0] KQ13 = 13'(KQ);
  localparam logic [24:0] DQ25 = 25'(DQ);

  // Single-correction reductions. Raw differences carry their borrow in the MSB.
  function automatic logic [11:0] red_add_k(input logic [12:0] s);
    return (s >= KQ13) ? 12'(s - KQ13) : s[11:0];
  endfunction

  function automatic logic [11:0] red_sub_k(input logic [12:0] d);
    return d[12] ? 12'(d + KQ13) : d[11:0];
  endfunction

  function automatic logic [23:0] red_add_d(input logic [24:0] s);
    return (s >= DQ25) ? 24'(s - DQ25) : s[23:0];
  endfunction

  function automatic logic [23:0] red_sub_d(input logic [24:0] d);
    return d[24] ? 24'(d + DQ25) : d[23:0];
  endfunction

  function automatic logic [23:0] reduce(input logic [1:0] m, input logic [12:0] hi,
                                         input logic [12:0] lo, input logic [24:0] w);
    logic [23:0] r;
    case (mode_t'(m))
      MODE_K2:   r = {red_add_k(hi), red_sub_k(lo)};
      MODE_K4:   r = {red_sub_k(hi), red_add_k(lo)};
      MODE_DADD: r = red_add_d(w);
      default:   r = red_sub_d(w);
    endcase
    return r;
  endfunction

  // ---------------- BH delay line (shifts on every non-hold cycle) ----------------
  logic [11:0] bhx_dly;

  if (BH_DLY == 0) begin : g_no_dly
    assign bhx_dly = bus.in_b[23:12];
  end else begin : g_dly
    logic [11:0] dl_q [BH_DLY];
    logic [11:0] dl_d [BH_DLY];

    always_comb begin
      for (int k = 0; k < BH_DLY; k++) dl_d[k] = dl_q[k];
      if (!bus.hold) begin
        dl_d[0] = bus.in_b[23:12];
        for (int k = 1; k < BH_DLY; k++) dl_d[k] = dl_q[k-1];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < BH_DLY; k++) dl_q[k] <= '0;
      end else begin
        for (int k = 0; k < BH_DLY; k++) dl_q[k] <= dl_d[k];
      end
    end

    assign bhx_dly = dl_q[BH_DLY-1];
  end

  // ---------------- Stage 0: raw sums/differences (combinational) ----------------
  logic [11:0]        ah, al, bh, bl, bhx;
  logic signed [12:0] diff_hi, diff_lo;
  logic signed [24:0] diff_w;
  logic [12:0]        raw_hi_p0, raw_lo_p0;
  logic [24:0]        raw_w_p0;

  always_comb begin
    ah  = bus.in_a[23:12];
    al  = bus.in_a[11:0];
    bh  = bus.in_b[23:12];
    bl  = bus.in_b[11:0];
    bhx = bus.intt ? bh : bhx_dly;
    diff_lo = $signed({1'b0, ah})     - $signed({1'b0, al});
    diff_hi = $signed({1'b0, bhx})    - $signed({1'b0, ah});
    diff_w  = $signed({1'b0, bus.in_b}) - $signed({1'b0, bus.in_a});
    raw_hi_p0 = {1'b0, ah} + {1'b0, al};
    raw_lo_p0 = $unsigned(diff_lo);
    raw_w_p0  = {1'b0, bus.in_a} + {1'b0, bus.in_b};
    case (mode_t'(bus.mode))
      MODE_K4: begin
        raw_hi_p0 = $unsigned(diff_hi);
        raw_lo_p0 = {1'b0, al} + {1'b0, bl};
      end
      MODE_DSUB: raw_w_p0 = $unsigned(diff_w);
      default: ;
    endcase
  end

  // Source of the final (reducing) stage: stage-1 registers or stage 0 directly.
  logic        vld_src;
  logic [1:0]  mode_src;
  logic [12:0] hi_src, lo_src;
  logic [24:0] w_src;

  if (PIPE == 1) begin : g_pipe1
    assign vld_src  = bus.in_valid;
    assign mode_src = bus.mode;
    assign hi_src   = raw_hi_p0;
    assign lo_src   = raw_lo_p0;
    assign w_src    = raw_w_p0;
  end else begin : g_pipe2
    // ---------------- Stage 1: register raw values and mode ----------------
    logic        vld_p1_q, vld_p1_d;
    logic [1:0]  mode_p1_q, mode_p1_d;
    logic [12:0] hi_p1_q, hi_p1_d, lo_p1_q, lo_p1_d;
    logic [24:0] w_p1_q, w_p1_d;

    always_comb begin
      vld_p1_d  = vld_p1_q;
      mode_p1_d = mode_p1_q;
      hi_p1_d   = hi_p1_q;
      lo_p1_d   = lo_p1_q;
      w_p1_d    = w_p1_q;
      if (!bus.hold) begin
        vld_p1_d = bus.in_valid;
        if (bus.in_valid) begin
          mode_p1_d = bus.mode;
          hi_p1_d   = raw_hi_p0;
          lo_p1_d   = raw_lo_p0;
          w_p1_d    = raw_w_p0;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_p1_q  <= 1'b0;
        mode_p1_q <= '0;
        hi_p1_q   <= '0;
        lo_p1_q   <= '0;
        w_p1_q    <= '0;
      end else begin
        vld_p1_q  <= vld_p1_d;
        mode_p1_q <= mode_p1_d;
        hi_p1_q   <= hi_p1_d;
        lo_p1_q   <= lo_p1_d;
        w_p1_q    <= w_p1_d;
      end
    end

    assign vld_src  = vld_p1_q;
    assign mode_src = mode_p1_q;
    assign hi_src   = hi_p1_q;
    assign lo_src   = lo_p1_q;
    assign w_src    = w_p1_q;
  end

  // ---------------- Output stage: reduce and register (stage PIPE) ----------------
  logic        vld_p2_q, vld_p2_d;
  logic [23:0] sum_p2_q, sum_p2_d;

  always_comb begin
    vld_p2_d = vld_p2_q;
    sum_p2_d = sum_p2_q;
    if (!bus.hold) begin
      vld_p2_d = vld_src;
      // out_sum only moves when a real result arrives; otherwise it keeps its last value.
      if (vld_src) sum_p2_d = reduce(mode_src, hi_src, lo_src, w_src);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2_q <= 1'b0;
      sum_p2_q <= '0;
    end else begin
      vld_p2_q <= vld_p2_d;
      sum_p2_q <= sum_p2_d;
    end
  end

  assign bus.out_valid = vld_p2_q;
  assign bus.out_sum   = sum_p2_q;

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// tb_mod_addsub_pipe
//   Directed bench for mod_addsub_pipe with default parameters
//   (KQ=3329, DQ=8380417, PIPE=2, BH_DLY=6).
module tb_mod_addsub_pipe;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  mod_addsub_pipe_if bus();

  mod_addsub_pipe #(.KQ(3329), .DQ(8380417), .PIPE(2), .BH_DLY(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic it,
                       input logic [23:0] a, input logic [23:0] b);
    bus.in_valid = v;
    bus.mode     = m;
    bus.intt     = it;
    bus.in_a     = a;
    bus.in_b     = b;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 1'b0, 24'd0, 24'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.out_valid);
    else n_pass++;
    n_checks++;
    if (bus.out_sum !== 24'd0) $display("FAIL reset_sum: got %0d expected 0", bus.out_sum);
    else n_pass++;
  endtask

  task automatic test_k2_wrap();
    drive(1'b1, 2'd0, 1'b0, {12'd3000, 12'd500}, 24'd0);
    step();
    idle();
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL k2_early_valid: got %b expected 0", bus.out_valid);
    else n_pass++;
    step();
    n_checks++;
    if (bus.out_valid !== 1'b1) $display("FAIL k2_valid: got %b expected 1", bus.out_valid);
    else n_pass++;
    n_checks++;
    if (bus.out_sum !== {12'd171, 12'd2500})
      $display("FAIL k2_sum: got %h expected %h", bus.out_sum, {12'd171, 12'd2500});
    else n_pass++;
    step();
  endtask

  task automatic test_k4_intt();
    drive(1'b1, 2'd1, 1'b1, {12'd100, 12'd3000}, {12'd50, 12'd400});
    step();
    idle();
    step();
    n_checks++;
    if (bus.out_valid !== 1'b1) $display("FAIL k4_intt_valid: got %b expected 1", bus.out_valid);
    else n_pass++;
    n_checks++;
    if (bus.out_sum !== {12'd3279, 12'd71})
      $display("FAIL k4_intt_sum: got %h expected %h", bus.out_sum, {12'd3279, 12'd71});
    else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 2'd2, 1'b0, 24'd8000000, 24'd1000000);
    step();
    drive(1'b1, 2'd3, 1'b0, 24'd5, 24'd3);
    step();
    idle();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 24'd619583)
      $display("FAIL d_add: got v=%b %0d expected v=1 619583", bus.out_valid, bus.out_sum);
    else n_pass++;
    step();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 24'd8380415)
      $display("FAIL d_sub: got v=%b %0d expected v=1 8380415", bus.out_valid, bus.out_sum);
    else n_pass++;
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL d_tail_valid: got %b expected 0", bus.out_valid);
    else n_pass++;
  endtask

  // BH=7 on cycle 0, then 0; K4/NTT operand A={2,0} issued on cycle issue_cyc.
  task automatic run_ntt(input int issue_cyc, input logic [11:0] exp_hi, input string name);
    do_reset();
    drive(1'b0, 2'd0, 1'b0, 24'd0, {12'd7, 12'd0});
    step();
    idle();
    for (int c = 1; c < issue_cyc; c++) step();
    drive(1'b1, 2'd1, 1'b0, {12'd2, 12'd0}, 24'd0);
    step();
    idle();
    step();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== {exp_hi, 12'd0})
      $display("FAIL %s: got v=%b %h expected v=1 %h", name, bus.out_valid, bus.out_sum, {exp_hi, 12'd0});
    else n_pass++;
    step();
  endtask

  task automatic test_k4_ntt();
    run_ntt(6, 12'd5, "k4_ntt_cyc6");
    run_ntt(5, 12'd3327, "k4_ntt_cyc5");
  endtask

  task automatic test_hold();
    do_reset();
    // op1 also pushes BH=7 into the delay line (shift 1)
    drive(1'b1, 2'd0, 1'b0, {12'd3000, 12'd500}, {12'd7, 12'd0});
    step();
    drive(1'b1, 2'd3, 1'b0, 24'd5, 24'd3);
    step();
    // freeze; the operand and BH presented here must be ignored
    bus.hold = 1'b1;
    drive(1'b1, 2'd2, 1'b0, 24'd1, 24'hFFF001);
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_sum !== {12'd171, 12'd2500})
        $display("FAIL hold_frozen[%0d]: got v=%b %h expected v=1 %h", i, bus.out_valid,
                 bus.out_sum, {12'd171, 12'd2500});
      else n_pass++;
    end
    bus.hold = 1'b0;
    idle();
    step();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 24'd8380415)
      $display("FAIL hold_op2: got v=%b %0d expected v=1 8380415", bus.out_valid, bus.out_sum);
    else n_pass++;
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_sum !== 24'd8380415)
      $display("FAIL hold_no_dup: got v=%b %0d expected v=0 8380415", bus.out_valid, bus.out_sum);
    else n_pass++;
    // four non-hold shifts so far; two more bring BH=7 to the delay-line tap
    step();
    step();
    drive(1'b1, 2'd1, 1'b0, {12'd2, 12'd0}, 24'd0);
    step();
    idle();
    step();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== {12'd5, 12'd0})
      $display("FAIL hold_dly_frozen: got v=%b %h expected v=1 %h", bus.out_valid, bus.out_sum,
               {12'd5, 12'd0});
    else n_pass++;
    step();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 2'd0, 1'b0, {12'd3000, 12'd500}, 24'd0);
    step();
    drive(1'b1, 2'd2, 1'b0, 24'd8000000, 24'd1000000);
    step();
    bus.hold = 1'b1;
    rst = 1'b1;
    idle();
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_sum !== 24'd0)
      $display("FAIL rstmid_clear: got v=%b %0d expected v=0 0", bus.out_valid, bus.out_sum);
    else n_pass++;
    rst = 1'b0;
    bus.hold = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (bus.out_valid !== 1'b0) $display("FAIL rstmid_stale[%0d]: got %b expected 0", i, bus.out_valid);
      else n_pass++;
    end
    drive(1'b1, 2'd2, 1'b0, 24'd1, 24'd2);
    step();
    idle();
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL rstmid_latency: got %b expected 0", bus.out_valid);
    else n_pass++;
    step();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 24'd3)
      $display("FAIL rstmid_fresh: got v=%b %0d expected v=1 3", bus.out_valid, bus.out_sum);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    bus.hold = 1'b0;
    idle();
    test_reset();
    test_k2_wrap();
    test_k4_intt();
    test_back_to_back();
    test_k4_ntt();
    test_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
